// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared BCD constants, digit type and the all-nines helper
//                for the score tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef logic [BCD_W-1:0] digit_t;

    // Packed-BCD value with the lowest `digits` digits set to 9 (up to 16 digits).
    function automatic logic [63:0] all_nines(input int digits);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < digits) begin
                v[i*BCD_W +: BCD_W] = BCD_NINE;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_cnt
//  Description : One decade of a packed-BCD counter. Counts 0..9 on inc,
//                wraps 9 -> 0 and raises carry_out in the wrapping cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cnt
    import score_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   inc,
    output logic   carry_out,
    output digit_t digit
);

    digit_t digit_q;
    digit_t digit_d;

    // Next digit value: clear wins over increment, 9 wraps to 0.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == BCD_NINE) ? digit_t'(0) : digit_q + digit_t'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign carry_out = inc & (digit_q == BCD_NINE);
    assign digit     = digit_q;

endmodule
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : score_tracker
//  Description : Synchronizes the raw collision level into clk, turns each
//                collision into one score increment with a hold-off window,
//                keeps a saturating packed-BCD score and (optionally) a high
//                score for the seven-segment driver.
//                Optional feature macro: SCORE_TRACKER_HISCORE_EN
//                (high-score register, game_over edge detect and new_high).
//  Revision    : 1.0 - initial release
// ============================================================================
module score_tracker
    import score_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hit_in,
    input  logic                    new_game,
    input  logic                    game_over,
    output logic [BCD_W*DIGITS-1:0] score_bcd,
    output logic [BCD_W*DIGITS-1:0] hiscore_bcd,
    output logic                    hit_pulse,
    output logic                    score_max,
    output logic                    new_high
);

    localparam int                    c_score_w   = BCD_W * DIGITS;
    localparam logic [c_score_w-1:0]  c_all_nines = c_score_w'(all_nines(DIGITS));
    localparam logic [CNT_W-1:0]      c_holdoff   = CNT_W'(HOLDOFF_CYCLES);

    logic [2:0]           sync_q;
    logic [CNT_W-1:0]     holdoff_q;
    logic [CNT_W-1:0]     holdoff_d;
    logic                 hit_pulse_q;
    logic                 w_edge;
    logic                 w_accept;
    logic [c_score_w-1:0] w_score;
    logic [DIGITS-1:0]    w_carry;
    logic                 w_carry_unused;

    // sync_q[0..2] are s1..s3; an edge is s2 high while s3 is still low.
    assign w_edge   = sync_q[1] & ~sync_q[2];
    assign w_accept = w_edge & (holdoff_q == '0) & ~game_over & ~new_game;

    // Three-flop synchronizer chain for the asynchronous collision level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], hit_in};
        end
    end

    // Hold-off next state: new_game clears, an accepted hit reloads, else count down to 0.
    always_comb begin
        holdoff_d = holdoff_q;
        if (new_game) begin
            holdoff_d = '0;
        end else if (w_accept) begin
            holdoff_d = c_holdoff;
        end else if (holdoff_q != '0) begin
            holdoff_d = holdoff_q - CNT_W'(1);
        end
    end

    // Hold-off counter and the registered hit strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            holdoff_q   <= '0;
            hit_pulse_q <= 1'b0;
        end else begin
            holdoff_q   <= holdoff_d;
            hit_pulse_q <= w_accept;
        end
    end

    // Digit 0 only steps on a live hit while not frozen and not saturated;
    // higher digits step on the carry of the digit below.
    assign w_carry[0] = hit_pulse_q & ~game_over & ~score_max;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i < DIGITS - 1) begin : g_mid
                bcd_digit_cnt u_digit (
                    .clk       (clk),
                    .reset     (reset),
                    .clr       (new_game),
                    .inc       (w_carry[i]),
                    .carry_out (w_carry[i+1]),
                    .digit     (w_score[i*BCD_W +: BCD_W])
                );
            end else begin : g_top
                bcd_digit_cnt u_digit (
                    .clk       (clk),
                    .reset     (reset),
                    .clr       (new_game),
                    .inc       (w_carry[i]),
                    .carry_out (w_carry_unused),
                    .digit     (w_score[i*BCD_W +: BCD_W])
                );
            end
        end
    endgenerate

    assign score_bcd = w_score;
    assign score_max = (w_score == c_all_nines);
    assign hit_pulse = hit_pulse_q;

`ifdef SCORE_TRACKER_HISCORE_EN
    logic                 game_over_q;
    logic [c_score_w-1:0] hiscore_q;
    logic [c_score_w-1:0] hiscore_d;
    logic                 new_high_q;
    logic                 new_high_d;
    logic                 w_go_rise;

    // On a game_over rise, capture the score if it beats the high score.
    // Packed BCD orders the same as plain binary, so an unsigned compare works.
    always_comb begin
        w_go_rise  = game_over & ~game_over_q;
        new_high_d = w_go_rise & (w_score > hiscore_q);
        hiscore_d  = new_high_d ? w_score : hiscore_q;
    end

    // High-score register, game_over history flop and the new_high strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_over_q <= 1'b0;
            hiscore_q   <= '0;
            new_high_q  <= 1'b0;
        end else begin
            game_over_q <= game_over;
            hiscore_q   <= hiscore_d;
            new_high_q  <= new_high_d;
        end
    end

    assign hiscore_bcd = hiscore_q;
    assign new_high    = new_high_q;
`else
    assign hiscore_bcd = '0;
    assign new_high    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Sits between the enemy/bullet collision logic and the seven-segment driver.
- Takes the raw collision level from the game-clock domain and synchronizes it into the display clock domain.
- Converts each collision into exactly one score increment, with a glitch hold-off window.
- Keeps a saturating packed-BCD score and, optionally, a high score, both presented to the segment driver.

Parameters:
- DIGITS, 4, number of BCD digits in the score and high-score outputs.
- HOLDOFF_CYCLES, 1000, clk cycles after an accepted hit during which further hit edges are dropped; 0 disables the hold-off.
- CNT_W, 16, width of the hold-off counter; must satisfy HOLDOFF_CYCLES < 2**CNT_W.

Ports:
- clk  input  1  display/main clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state, including the high score.
- hit_in  input  1  raw collision level (collision | collision2), asynchronous to clk.
- new_game  input  1  synchronous, active-high; clears the score, keeps the high score.
- game_over  input  1  level; while high, the score is frozen.
- score_bcd  output  4*DIGITS  packed BCD score; digit 0 in bits [3:0].
- hiscore_bcd  output  4*DIGITS  packed BCD high score.
- hit_pulse  output  1  one-cycle strobe for each accepted hit.
- score_max  output  1  high while the score is all 9s (for DIGITS=4, 9999).
- new_high  output  1  one-cycle strobe when the high score is updated.

Behaviour:
- Reset values: every output is 0; the synchronizer flops, hold-off counter and game_over history flop are also 0.
- Synchronizer and edge detect:
  - hit_in passes through a 3-flop shift chain s1 -> s2 -> s3.
  - An edge is detected when s2 & ~s3.
  - hit_pulse is registered: it goes high on the 3rd rising edge after hit_in is first sampled high, for exactly one cycle.
- Acceptance: an edge is accepted only if all of the following hold in that cycle: holdoff counter == 0, game_over == 0, new_game == 0. A dropped edge produces no hit_pulse.
- Hold-off counter:
  - On an accepted edge it loads HOLDOFF_CYCLES.
  - Otherwise it decrements toward 0 and holds at 0.
- Score update:
  - The cycle after hit_pulse, score_bcd is incremented by 1 in BCD.
  - Each digit wraps 9 -> 0 and carries into the next digit.
  - At all 9s the score saturates: no change, no wrap. score_max is combinational from score_bcd.
  - Observed latency from hit_in being first sampled high to the new score_bcd value: 4 clk edges.
- new_game: next edge sets score_bcd to 0. It takes priority over a pending increment in the same cycle, and it also clears the hold-off counter.
- game_over:
  - Increments are inhibited while it is high.
  - On its rising edge (registered history flop): if score_bcd > hiscore_bcd, hiscore_bcd <= score_bcd on the next edge and new_high pulses on that same edge.
  - The comparison is unsigned; packed BCD compares correctly as binary.
- Simultaneous events:
  - reset dominates everything.
  - new_game dominates an increment.
  - A game_over rise in the same cycle as hit_pulse: the increment is dropped, and the comparison uses the un-incremented score.
- Reset asserted mid-hold-off clears the counter; the first hit after reset is accepted.
- Illegal BCD digits (>9) cannot arise from this logic and need no handling.

Optional Feature:
- Macro: SCORE_TRACKER_HISCORE_EN.
- Defined: the high-score register, the game_over edge detect and new_high are implemented as described above.
- Undefined: hiscore_bcd is tied to 0, new_high is tied to 0, and no comparator or high-score register is built. game_over still inhibits increments.

Decomposition:
- Shared package score_pkg holds:
  - BCD_W = 4;
  - BCD_NINE = 4'd9;
  - a function for the all-nines constant, given DIGITS;
  - a digit typedef (logic [3:0]).
- One natural sub-module: bcd_digit_cnt, with ports clk, reset, clr, inc (carry in), carry_out and digit[3:0]. score_tracker instantiates it DIGITS times, gating inc with the saturation flag.

Test Plan:
- Hold hit_in high for 20 cycles starting at cycle 10, with HOLDOFF_CYCLES=8 -> exactly one hit_pulse at cycle 13 and score_bcd = 16'h0001 at cycle 14.
- Two hit_in rises 5 cycles apart with HOLDOFF_CYCLES=8 -> second dropped, score = 16'h0001. Repeat with 12 cycles apart -> score = 16'h0002.
- Preload 0099 via 99 hits, then one more hit -> score = 16'h0100. From 9999, one more hit -> stays 16'h9999 with score_max = 1; hit_pulse still fires.
- Score 0042 with hiscore 0030, game_over rises -> hiscore = 16'h0042 and one new_high strobe. Then new_game plus 5 hits and another game_over rise -> hiscore stays 16'h0042, no new_high.
- new_game asserted in the same cycle as hit_pulse -> score = 16'h0000. With game_over high, hit_in toggling -> score unchanged, no hit_pulse.
- reset pulse mid-hold-off with hiscore = 16'h0042 -> all outputs 0. A hit 4 cycles later is accepted. With the macro undefined: hiscore_bcd and new_high stay 0 throughout.
